lab5_mcore_mem_req_arbiter: RTL and testbench

Shares one memory request/response port among p_num_reqs requesters, such as per-core icache and dcache ports in the multicore system.
- Arbitrates requests round-robin over val/rdy interfaces.
- Records the granted requester ID of every in-flight request in an internal in-order tracking FIFO.
- Steers each memory response back to the requester named at the FIFO head.
- Sits between the processor/cache ports and the single memory port.

---
 rtl/lab5_mcore_mem_req_arbiter_if.sv | 30 +++
 rtl/lab5_mcore_mem_req_arbiter.sv | 112 +++++++++++
 tb/tb_lab5_mcore_mem_req_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/lab5_mcore_mem_req_arbiter_if.sv
// Bus bundle for the memory request arbiter: requester side, memory side and response steering.
// All links are val/rdy: a transfer fires on a cycle where val and rdy are both high; val must hold until fire.
interface lab5_mcore_mem_req_arbiter_if #(
    parameter int p_num_reqs   = 2,
    parameter int p_req_nbits  = 77,
    parameter int p_resp_nbits = 47
);
    logic [p_num_reqs-1:0]             req_val;
    logic [p_num_reqs-1:0]             req_rdy;
    logic [p_num_reqs*p_req_nbits-1:0] req_msg;
    logic                              memreq_val;
    logic                              memreq_rdy;
    logic [p_req_nbits-1:0]            memreq_msg;
    logic                              memresp_val;
    logic                              memresp_rdy;
    logic [p_resp_nbits-1:0]           memresp_msg;
    logic [p_num_reqs-1:0]             resp_val;
    logic [p_num_reqs-1:0]             resp_rdy;
    logic [p_resp_nbits-1:0]           resp_msg;

    modport slave (
        input  req_val, req_msg, memreq_rdy, memresp_val, memresp_msg, resp_rdy,
        output req_rdy, memreq_val, memreq_msg, memresp_rdy, resp_val, resp_msg
    );

    modport master (
        output req_val, req_msg, memreq_rdy, memresp_val, memresp_msg, resp_rdy,
        input  req_rdy, memreq_val, memreq_msg, memresp_rdy, resp_val, resp_msg
    );
endinterface

// File: rtl/lab5_mcore_mem_req_arbiter.sv
// Round-robin arbiter sharing one memory port, with an in-order ID FIFO steering responses back.
// LAB5_MCORE_ARB_FIXED_PRIO_EN selects fixed lowest-index priority; LAB5_MCORE_ARB_CHECK_EN enables the empty-response check.
module lab5_mcore_mem_req_arbiter #(
    parameter int p_num_reqs   = 2,
    parameter int p_req_nbits  = 77,
    parameter int p_resp_nbits = 47,
    parameter int p_max_outst  = 4
) (
    input logic clk,
    input logic reset,
    lab5_mcore_mem_req_arbiter_if.slave bus
);
    localparam int id_w  = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1;
    localparam int ptr_w = $clog2(p_max_outst);
    localparam int cnt_w = ptr_w + 1;

    logic [id_w-1:0]  winner;
    logic [id_w-1:0]  head_id;
    logic [id_w-1:0]  fifo_ids [p_max_outst];
    logic [ptr_w-1:0] head;
    logic [ptr_w-1:0] tail;
    logic [cnt_w-1:0] count;
    logic             any_req;
    logic             empty;
    logic             full_blocked;
    logic             push_fire;
    logic             pop_fire;

`ifdef LAB5_MCORE_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int k = p_num_reqs - 1; k >= 0; k--) begin
            if (bus.req_val[k]) winner = id_w'(k);
        end
    end
`else
    logic [id_w-1:0] prio;
    logic            found;
    int              idx;

    // Scan starts at the priority pointer and wraps, so the last winner goes to the back.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < p_num_reqs; k++) begin
            idx = int'(prio) + k;
            if (idx >= p_num_reqs) idx = idx - p_num_reqs;
            if (!found && bus.req_val[idx]) begin
                found  = 1'b1;
                winner = id_w'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio <= '0;
        end else if (push_fire) begin
            prio <= (winner == id_w'(p_num_reqs - 1)) ? '0 : winner + id_w'(1);
        end
    end
`endif

    assign any_req      = |bus.req_val;
    assign empty        = (count == '0);
    assign head_id      = fifo_ids[head];
    assign pop_fire     = bus.memresp_val & bus.memresp_rdy;
    // A response leaving this cycle frees the slot the new request needs.
    assign full_blocked = (count == cnt_w'(p_max_outst)) & ~pop_fire;
    assign push_fire    = bus.memreq_val & bus.memreq_rdy;

    assign bus.memreq_val  = any_req & ~full_blocked & ~reset;
    assign bus.memreq_msg  = any_req ? bus.req_msg[winner*p_req_nbits +: p_req_nbits] : '0;
    assign bus.memresp_rdy = bus.resp_rdy[head_id] & ~empty;
    assign bus.resp_msg    = bus.memresp_msg;

    always_comb begin
        bus.req_rdy = '0;
        if (any_req && bus.memreq_rdy && !full_blocked && !reset) bus.req_rdy[winner] = 1'b1;
    end

    always_comb begin
        bus.resp_val = '0;
        if (bus.memresp_val && !empty) bus.resp_val[head_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_fire) fifo_ids[tail] <= winner;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_fire) tail <= tail + ptr_w'(1);
            if (pop_fire)  head <= head + ptr_w'(1);
            case ({push_fire, pop_fire})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef LAB5_MCORE_ARB_CHECK_EN
    assert property (@(posedge clk) disable iff (reset) !(bus.memresp_val && empty))
        else $error("memory response arrived with no request in flight");
`endif
endmodule

// File: tb/tb_lab5_mcore_mem_req_arbiter.sv
// Directed bench for the memory request arbiter with p_num_reqs=2 and p_max_outst=4.
// Expected grant order follows LAB5_MCORE_ARB_FIXED_PRIO_EN when it is defined.
module tb_lab5_mcore_mem_req_arbiter;
  localparam int N  = 2;
  localparam int RW = 77;
  localparam int SW = 47;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lab5_mcore_mem_req_arbiter_if #(.p_num_reqs(N), .p_req_nbits(RW), .p_resp_nbits(SW)) bus();

  lab5_mcore_mem_req_arbiter #(
    .p_num_reqs(N), .p_req_nbits(RW), .p_resp_nbits(SW), .p_max_outst(MO)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [0:0] exp_q[$];
  int rr_exp[4];
  int ooo_seq[3];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] req_word(input int id, input int n);
    logic [RW-1:0] w;
    w = '0;
    w[RW-1:RW-8] = 8'hA5;
    w[39:32] = id[7:0];
    w[31:0] = n;
    return w;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  task automatic set_reqs(input logic [N-1:0] v, input int n);
    bus.req_val = v;
    bus.req_msg = {req_word(1, n), req_word(0, n)};
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g;
    logic [SW-1:0] rmsg;
`ifdef LAB5_MCORE_ARB_FIXED_PRIO_EN
    rr_exp = '{0, 0, 0, 0};
`else
    rr_exp = '{0, 1, 0, 1};
`endif
    ooo_seq = '{1, 0, 1};

    bus.req_val = '0;
    bus.req_msg = '0;
    bus.memreq_rdy = 1'b0;
    bus.memresp_val = 1'b0;
    bus.memresp_msg = '0;
    bus.resp_rdy = '0;

    // reset state
    #2;
    check("rst_memreq_val", bus.memreq_val, 1'b0);
    check("rst_req_rdy", bus.req_rdy, 2'b00);
    check("rst_memresp_rdy", bus.memresp_rdy, 1'b0);
    check("rst_resp_val", bus.resp_val, 2'b00);
    check("rst_memreq_msg", bus.memreq_msg, '0);
    #10 reset = 1'b0;
    next_cycle();

    // round-robin with both requesters asserted, filling the FIFO
    bus.memreq_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_reqs(2'b11, k);
      #1;
      g = rr_exp[k];
      check("rr_memreq_val", bus.memreq_val, 1'b1);
      check("rr_req_rdy", bus.req_rdy, onehot(g));
      check("rr_memreq_msg", bus.memreq_msg, req_word(g, k));
      exp_q.push_back(1'(g));
      next_cycle();
    end

    // full: no new request may issue
    check("full_memreq_val", bus.memreq_val, 1'b0);
    check("full_req_rdy", bus.req_rdy, 2'b00);

    // full plus a same-cycle response: both fire
    rmsg = 47'h1234_5678_9AB;
    bus.memresp_val = 1'b1;
    bus.memresp_msg = rmsg;
    bus.resp_rdy = 2'b11;
    set_reqs(2'b11, 4);
    #1;
    check("fullpop_memreq_val", bus.memreq_val, 1'b1);
    check("fullpop_req_rdy", bus.req_rdy, onehot(0));
    check("fullpop_memreq_msg", bus.memreq_msg, req_word(0, 4));
    check("fullpop_resp_val", bus.resp_val, onehot(int'(exp_q[0])));
    check("fullpop_memresp_rdy", bus.memresp_rdy, 1'b1);
    check("fullpop_resp_msg", bus.resp_msg, rmsg);
    next_cycle();
    void'(exp_q.pop_front());
    exp_q.push_back(1'b0);

    // count stayed at 4
    bus.memresp_val = 1'b0;
    #1;
    check("still_full_memreq_val", bus.memreq_val, 1'b0);

    // backpressure on the head requester
    bus.req_val = '0;
    bus.memresp_val = 1'b1;
    g = int'(exp_q[0]);
    bus.resp_rdy = ~onehot(g);
    for (int k = 0; k < 3; k++) begin
      bus.memresp_msg = 47'(100 + k);
      #1;
      check("bp_resp_val", bus.resp_val, onehot(g));
      check("bp_memresp_rdy", bus.memresp_rdy, 1'b0);
      next_cycle();
    end
    bus.resp_rdy = onehot(g);
    #1;
    check("bp_release_memresp_rdy", bus.memresp_rdy, 1'b1);
    next_cycle();
    void'(exp_q.pop_front());

    // drain remaining entries in issue order
    bus.resp_rdy = 2'b11;
    while (exp_q.size() > 0) begin
      g = int'(exp_q.pop_front());
      rmsg = 47'($urandom_range(1, 32'h7fff_ffff));
      bus.memresp_msg = rmsg;
      #1;
      check("drain_resp_val", bus.resp_val, onehot(g));
      check("drain_resp_msg", bus.resp_msg, rmsg);
      check("drain_memresp_rdy", bus.memresp_rdy, 1'b1);
      next_cycle();
    end
    bus.memresp_val = 1'b0;
    #1;
    check("empty_resp_val", bus.resp_val, 2'b00);
    next_cycle();

    // issue 1,0,1 then return responses three cycles after each request
    for (int k = 0; k < 3; k++) begin
      set_reqs(onehot(ooo_seq[k]), 10 + k);
      #1;
      check("ooo_req_rdy", bus.req_rdy, onehot(ooo_seq[k]));
      check("ooo_memreq_msg", bus.memreq_msg, req_word(ooo_seq[k], 10 + k));
      exp_q.push_back(1'(ooo_seq[k]));
      next_cycle();
    end
    bus.req_val = '0;
    bus.memresp_val = 1'b1;
    for (int k = 0; k < 3; k++) begin
      g = int'(exp_q.pop_front());
      #1;
      check("ooo_resp_val", bus.resp_val, onehot(g));
      check("ooo_memresp_rdy", bus.memresp_rdy, 1'b1);
      next_cycle();
    end
    bus.memresp_val = 1'b0;

    // two in flight from requester 0, then reset mid-stream
    for (int k = 0; k < 2; k++) begin
      set_reqs(2'b01, 20 + k);
      #1;
      check("pre_rst_req_rdy", bus.req_rdy, 2'b01);
      next_cycle();
    end
    bus.memresp_val = 1'b1;
    #1;
    check("pre_rst_memresp_rdy", bus.memresp_rdy, 1'b1);
    check("pre_rst_resp_val", bus.resp_val, 2'b01);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_memreq_val", bus.memreq_val, 1'b0);
    check("mid_rst_req_rdy", bus.req_rdy, 2'b00);
    check("mid_rst_memresp_rdy", bus.memresp_rdy, 1'b0);
    check("mid_rst_resp_val", bus.resp_val, 2'b00);
    exp_q.delete();
    #1 reset = 1'b0;
    bus.req_val = '0;
    #1;
    check("stray_memresp_rdy", bus.memresp_rdy, 1'b0);
    check("stray_resp_val", bus.resp_val, 2'b00);
    next_cycle();
    check("stray_after_edge_memresp_rdy", bus.memresp_rdy, 1'b0);

    // pointer back at 0 after reset
    bus.memresp_val = 1'b0;
    set_reqs(2'b11, 30);
    #1;
    check("post_rst_req_rdy", bus.req_rdy, 2'b01);
    check("post_rst_memreq_msg", bus.memreq_msg, req_word(0, 30));
    next_cycle();
    bus.req_val = '0;
    bus.memreq_rdy = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
